// File: rtl/model_trainer_arbiter.sv
// Round-robin arbiter/sequencer sharing one vector summation engine among the
// four gradient accumulations of the FNN trainer (dW, dK, dU, db).
// Grants one requester, pulses engine START, muxes the requester's operands
// onto the engine, waits for READY, latches the result and pulses DONE.
module model_trainer_arbiter #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input  logic                   CLK,
  input  logic                   RST,

  input  logic [3:0]             REQ_IN,
  output logic [3:0]             GNT_OUT,
  output logic [3:0]             DONE_OUT,

  input  logic [4*DATA_SIZE-1:0] SIZE_IN,
  input  logic [4*DATA_SIZE-1:0] LENGTH_IN,
  input  logic [4*DATA_SIZE-1:0] DATA_IN,
  input  logic [3:0]             DATA_IN_VECTOR_ENABLE,
  input  logic [3:0]             DATA_IN_SCALAR_ENABLE,

  output logic [DATA_SIZE-1:0]   DATA_OUT,
  output logic [3:0]             DATA_OUT_VECTOR_ENABLE,
  output logic [3:0]             DATA_OUT_SCALAR_ENABLE,
  output logic [DATA_SIZE-1:0]   RESULT_OUT,

  output logic                   ENGINE_START,
  input  logic                   ENGINE_READY,
  output logic [DATA_SIZE-1:0]   ENGINE_SIZE_IN,
  output logic [DATA_SIZE-1:0]   ENGINE_LENGTH_IN,
  output logic [DATA_SIZE-1:0]   ENGINE_DATA_IN,
  output logic                   ENGINE_DATA_IN_VECTOR_ENABLE,
  output logic                   ENGINE_DATA_IN_SCALAR_ENABLE,
  input  logic [DATA_SIZE-1:0]   ENGINE_DATA_OUT,
  input  logic                   ENGINE_DATA_OUT_VECTOR_ENABLE,
  input  logic                   ENGINE_DATA_OUT_SCALAR_ENABLE
);

  // CONTROL_SIZE belongs to the engine; only sanity-check it here.
  if (CONTROL_SIZE < 1) begin : g_bad_control_size
    $error("CONTROL_SIZE must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_BUSY    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [1:0]             r_last;
  logic [3:0]             r_gnt;
  logic [3:0]             r_done;
  logic                   r_start;
  logic [DATA_SIZE-1:0]   r_result;

  logic                   w_req_found;
  logic [1:0]             w_req_idx;
  logic [1:0]             w_cand;
  logic [1:0]             w_gnt_idx;
  logic                   w_any_gnt;

  // Round-robin pick: first request scanning LAST+1, LAST+2, ... modulo 4.
  always_comb begin
    w_req_found = 1'b0;
    w_req_idx   = 2'd0;
    w_cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_last + 2'(k);
      if (!w_req_found && REQ_IN[w_cand]) begin
        w_req_found = 1'b1;
        w_req_idx   = w_cand;
      end
    end
  end

  // Encode the registered one-hot grant into an index for the operand muxes.
  always_comb begin
    w_gnt_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (r_gnt[i]) begin
        w_gnt_idx = 2'(i);
      end
    end
  end

  assign w_any_gnt = |r_gnt;

  // Sequencer: grant, one-cycle START, wait READY, one-cycle DONE, release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_last   <= 2'd3;
      r_gnt    <= 4'd0;
      r_done   <= 4'd0;
      r_start  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_found) begin
            r_gnt   <= 4'd1 << w_req_idx;
            r_start <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          // READY is deliberately ignored while START is on the wire.
          r_start <= 1'b0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (ENGINE_READY) begin
            r_result <= ENGINE_DATA_OUT;
            r_done   <= r_gnt;
            r_last   <= w_gnt_idx;
            r_state  <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_gnt   <= 4'd0;
          r_done  <= 4'd0;
          r_state <= S_IDLE;
        end
        default: begin
          r_gnt   <= 4'd0;
          r_done  <= 4'd0;
          r_start <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign GNT_OUT      = r_gnt;
  assign DONE_OUT     = r_done;
  assign ENGINE_START = r_start;
  assign RESULT_OUT   = r_result;

  // Operand mux toward the engine; everything reads zero when nobody is granted.
  assign ENGINE_SIZE_IN   = w_any_gnt ? SIZE_IN[int'(w_gnt_idx)*DATA_SIZE +: DATA_SIZE]   : '0;
  assign ENGINE_LENGTH_IN = w_any_gnt ? LENGTH_IN[int'(w_gnt_idx)*DATA_SIZE +: DATA_SIZE] : '0;
  assign ENGINE_DATA_IN   = w_any_gnt ? DATA_IN[int'(w_gnt_idx)*DATA_SIZE +: DATA_SIZE]   : '0;
  assign ENGINE_DATA_IN_VECTOR_ENABLE = |(DATA_IN_VECTOR_ENABLE & r_gnt);
  assign ENGINE_DATA_IN_SCALAR_ENABLE = |(DATA_IN_SCALAR_ENABLE & r_gnt);

  // Engine output path: data is shared, enables go only to the granted requester.
  assign DATA_OUT               = ENGINE_DATA_OUT;
  assign DATA_OUT_VECTOR_ENABLE = {4{ENGINE_DATA_OUT_VECTOR_ENABLE}} & r_gnt;
  assign DATA_OUT_SCALAR_ENABLE = {4{ENGINE_DATA_OUT_SCALAR_ENABLE}} & r_gnt;

endmodule

// File: tb/tb_model_trainer_arbiter.sv
// Self-checking bench for model_trainer_arbiter: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_model_trainer_arbiter;
  localparam int DW = 64;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [3:0]      REQ_IN = '0;
  logic [3:0]      GNT_OUT, DONE_OUT;
  logic [4*DW-1:0] SIZE_IN = '0, LENGTH_IN = '0, DATA_IN = '0;
  logic [3:0]      DATA_IN_VECTOR_ENABLE = '0, DATA_IN_SCALAR_ENABLE = '0;
  logic [DW-1:0]   DATA_OUT, RESULT_OUT;
  logic [3:0]      DATA_OUT_VECTOR_ENABLE, DATA_OUT_SCALAR_ENABLE;
  logic            ENGINE_START;
  logic            ENGINE_READY = 1'b0;
  logic [DW-1:0]   ENGINE_SIZE_IN, ENGINE_LENGTH_IN, ENGINE_DATA_IN;
  logic            ENGINE_DATA_IN_VECTOR_ENABLE, ENGINE_DATA_IN_SCALAR_ENABLE;
  logic [DW-1:0]   ENGINE_DATA_OUT = '0;
  logic            ENGINE_DATA_OUT_VECTOR_ENABLE = 1'b0;
  logic            ENGINE_DATA_OUT_SCALAR_ENABLE = 1'b0;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  model_trainer_arbiter #(.DATA_SIZE(DW), .CONTROL_SIZE(4)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_IN(REQ_IN), .GNT_OUT(GNT_OUT), .DONE_OUT(DONE_OUT),
    .SIZE_IN(SIZE_IN), .LENGTH_IN(LENGTH_IN), .DATA_IN(DATA_IN),
    .DATA_IN_VECTOR_ENABLE(DATA_IN_VECTOR_ENABLE),
    .DATA_IN_SCALAR_ENABLE(DATA_IN_SCALAR_ENABLE),
    .DATA_OUT(DATA_OUT),
    .DATA_OUT_VECTOR_ENABLE(DATA_OUT_VECTOR_ENABLE),
    .DATA_OUT_SCALAR_ENABLE(DATA_OUT_SCALAR_ENABLE),
    .RESULT_OUT(RESULT_OUT),
    .ENGINE_START(ENGINE_START), .ENGINE_READY(ENGINE_READY),
    .ENGINE_SIZE_IN(ENGINE_SIZE_IN), .ENGINE_LENGTH_IN(ENGINE_LENGTH_IN),
    .ENGINE_DATA_IN(ENGINE_DATA_IN),
    .ENGINE_DATA_IN_VECTOR_ENABLE(ENGINE_DATA_IN_VECTOR_ENABLE),
    .ENGINE_DATA_IN_SCALAR_ENABLE(ENGINE_DATA_IN_SCALAR_ENABLE),
    .ENGINE_DATA_OUT(ENGINE_DATA_OUT),
    .ENGINE_DATA_OUT_VECTOR_ENABLE(ENGINE_DATA_OUT_VECTOR_ENABLE),
    .ENGINE_DATA_OUT_SCALAR_ENABLE(ENGINE_DATA_OUT_SCALAR_ENABLE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  // Transaction view: who holds the engine, how many edges since the grant,
  // whether the completion pulse is showing, last winner, latched result.
  int            m_owner = -1;
  int            m_age   = 0;
  bit            m_done  = 0;
  int            m_last  = 3;
  logic [DW-1:0] m_result = '0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_owner = -1; m_age = 0; m_done = 0; m_last = 3; m_result = '0;
    end else if (m_done) begin
      m_owner = -1; m_done = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (m_owner < 0 && REQ_IN[(m_last + k) % 4]) begin
          m_owner = (m_last + k) % 4;
          m_age   = 0;
        end
      end
    end else begin
      // The edge right after the grant is the START cycle: READY does not count.
      if (m_age >= 1 && ENGINE_READY) begin
        m_done = 1; m_result = ENGINE_DATA_OUT; m_last = m_owner;
      end
      m_age++;
    end
  end

  // Every mid-cycle: compare all outputs with the model.
  always @(negedge CLK) begin
    logic [3:0] eg;
    if (chk_en) begin
      eg = (m_owner < 0) ? 4'd0 : (4'd1 << m_owner);
      chk("gnt", DW'(GNT_OUT), DW'(eg));
      chk("done", DW'(DONE_OUT), m_done ? DW'(eg) : '0);
      chk("start", DW'(ENGINE_START), DW'(m_owner >= 0 && m_age == 0 && !m_done));
      chk("result", RESULT_OUT, m_result);
      chk("eng_size", ENGINE_SIZE_IN, (m_owner < 0) ? '0 : SIZE_IN[m_owner*DW +: DW]);
      chk("eng_len", ENGINE_LENGTH_IN, (m_owner < 0) ? '0 : LENGTH_IN[m_owner*DW +: DW]);
      chk("eng_data", ENGINE_DATA_IN, (m_owner < 0) ? '0 : DATA_IN[m_owner*DW +: DW]);
      chk("eng_ven", DW'(ENGINE_DATA_IN_VECTOR_ENABLE),
          (m_owner < 0) ? '0 : DW'(DATA_IN_VECTOR_ENABLE[m_owner]));
      chk("eng_sen", DW'(ENGINE_DATA_IN_SCALAR_ENABLE),
          (m_owner < 0) ? '0 : DW'(DATA_IN_SCALAR_ENABLE[m_owner]));
      chk("data_out", DATA_OUT, ENGINE_DATA_OUT);
      chk("out_ven", DW'(DATA_OUT_VECTOR_ENABLE), ENGINE_DATA_OUT_VECTOR_ENABLE ? DW'(eg) : '0);
      chk("out_sen", DW'(DATA_OUT_SCALAR_ENABLE), ENGINE_DATA_OUT_SCALAR_ENABLE ? DW'(eg) : '0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK); #2;
  endtask

  task automatic wait_start(output int idx);
    idx = -1;
    for (int n = 0; n < 20 && idx < 0; n++) begin
      tick();
      if (ENGINE_START) idx = oh2i(GNT_OUT);
    end
    if (idx < 0) chk("start_timeout", DW'(ENGINE_START), DW'(1));
  endtask

  // One full transaction: READY arrives lat edges after the START cycle.
  task automatic do_tx(input int lat, input logic [3:0] drop, output int idx);
    int starts;
    wait_start(idx);
    starts = 1;
    for (int n = 0; n < lat; n++) begin tick(); starts += int'(ENGINE_START); end
    ENGINE_READY = 1'b1;
    tick();
    starts += int'(ENGINE_START);
    ENGINE_READY = 1'b0;
    chk("tx_done", DW'(DONE_OUT), (idx < 0) ? '0 : DW'(4'd1 << idx));
    chk("tx_one_start", DW'(starts), DW'(1));
    REQ_IN = REQ_IN & ~drop;
    tick();
    chk("tx_release", DW'(GNT_OUT), '0);
  endtask

  task automatic pulse_reset();
    RST = 1'b1; tick(); RST = 1'b0;
  endtask

  int idx;
  int order [5];

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_gnt", DW'(GNT_OUT), '0);
    chk("rst_done", DW'(DONE_OUT), '0);
    chk("rst_start", DW'(ENGINE_START), '0);
    chk("rst_result", RESULT_OUT, '0);
    RST = 1'b0;
    chk_en = 1;

    // Single request with literal operands
    SIZE_IN[0 +: DW] = 64'd4;
    LENGTH_IN[0 +: DW] = 64'd3;
    REQ_IN = 4'b0001;
    tick();
    chk("t1_gnt", DW'(GNT_OUT), DW'(4'b0001));
    chk("t1_start", DW'(ENGINE_START), DW'(1));
    chk("t1_size", ENGINE_SIZE_IN, 64'd4);
    chk("t1_len", ENGINE_LENGTH_IN, 64'd3);
    tick();
    chk("t1_start_low", DW'(ENGINE_START), '0);
    ENGINE_DATA_OUT = 64'h2A;
    ENGINE_READY = 1'b1;
    tick();
    ENGINE_READY = 1'b0;
    REQ_IN = 4'b0000;
    chk("t1_done", DW'(DONE_OUT), DW'(4'b0001));
    chk("t1_result", RESULT_OUT, 64'h2A);
    tick();
    chk("t1_gnt_clr", DW'(GNT_OUT), '0);
    chk("t1_done_clr", DW'(DONE_OUT), '0);

    // Round-robin with all four requesting
    pulse_reset();
    REQ_IN = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      do_tx(5, (t == 4) ? 4'b1111 : 4'b0000, idx);
      order[t] = idx;
    end
    chk("rr0", DW'(order[0]), DW'(0));
    chk("rr1", DW'(order[1]), DW'(1));
    chk("rr2", DW'(order[2]), DW'(2));
    chk("rr3", DW'(order[3]), DW'(3));
    chk("rr4", DW'(order[4]), DW'(0));

    // Wrap-around: after requester 3, requester 0 comes first
    REQ_IN = 4'b1000;
    do_tx(2, 4'b1000, idx);
    chk("wrap_first", DW'(idx), DW'(3));
    REQ_IN = 4'b1001;
    do_tx(2, 4'b0001, idx);
    chk("wrap_second", DW'(idx), DW'(0));
    do_tx(1, 4'b1000, idx);
    chk("wrap_third", DW'(idx), DW'(3));

    // Routing of enables
    REQ_IN = 4'b0100;
    wait_start(idx);
    tick();
    ENGINE_DATA_OUT_VECTOR_ENABLE = 1'b1;
    #1 chk("route_ven", DW'(DATA_OUT_VECTOR_ENABLE), DW'(4'b0100));
    DATA_IN_VECTOR_ENABLE = 4'b0010;
    #1 chk("route_in_ven1", DW'(ENGINE_DATA_IN_VECTOR_ENABLE), '0);
    DATA_IN_VECTOR_ENABLE = 4'b0100;
    #1 chk("route_in_ven2", DW'(ENGINE_DATA_IN_VECTOR_ENABLE), DW'(1));
    tick();
    ENGINE_DATA_OUT_VECTOR_ENABLE = 1'b0;
    DATA_IN_VECTOR_ENABLE = 4'b0000;
    ENGINE_READY = 1'b1; tick(); ENGINE_READY = 1'b0;
    chk("route_done", DW'(DONE_OUT), DW'(4'b0100));
    REQ_IN = 4'b0000;
    tick();

    // READY during START is ignored; request drop does not abort
    REQ_IN = 4'b0010;
    wait_start(idx);
    ENGINE_READY = 1'b1;
    tick();
    ENGINE_READY = 1'b0;
    chk("rs_no_done", DW'(DONE_OUT), '0);
    chk("rs_gnt_held", DW'(GNT_OUT), DW'(4'b0010));
    REQ_IN = 4'b0000;
    tick(); tick();
    chk("drop_no_done", DW'(DONE_OUT), '0);
    chk("drop_gnt_held", DW'(GNT_OUT), DW'(4'b0010));
    ENGINE_DATA_OUT = 64'h1234_5678_9ABC_DEF0;
    ENGINE_READY = 1'b1; tick(); ENGINE_READY = 1'b0;
    chk("drop_done", DW'(DONE_OUT), DW'(4'b0010));
    chk("drop_result", RESULT_OUT, 64'h1234_5678_9ABC_DEF0);
    tick();

    // Asynchronous reset in BUSY
    REQ_IN = 4'b0001;
    wait_start(idx);
    tick();
    ENGINE_DATA_OUT = 64'h55;
    #2 RST = 1'b1;
    #1;
    chk("arst_gnt", DW'(GNT_OUT), '0);
    chk("arst_start", DW'(ENGINE_START), '0);
    chk("arst_done", DW'(DONE_OUT), '0);
    chk("arst_result", RESULT_OUT, '0);
    REQ_IN = 4'b0000;
    ENGINE_READY = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    ENGINE_READY = 1'b0;
    chk("arst_no_done", DW'(DONE_OUT), '0);
    REQ_IN = 4'b1000;
    tick();
    chk("arst_grant3", DW'(GNT_OUT), DW'(4'b1000));
    tick();
    ENGINE_READY = 1'b1; tick(); ENGINE_READY = 1'b0;
    REQ_IN = 4'b0000;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!REQ_IN[r]) begin
          if ($urandom_range(3) == 0) REQ_IN[r] = 1'b1;
        end else if (DONE_OUT[r]) begin
          if ($urandom_range(1) == 0) REQ_IN[r] = 1'b0;
        end else if ($urandom_range(31) == 0) begin
          REQ_IN[r] = 1'b0;
        end
        SIZE_IN[r*DW +: DW]   = {$urandom, $urandom};
        LENGTH_IN[r*DW +: DW] = {$urandom, $urandom};
        DATA_IN[r*DW +: DW]   = {$urandom, $urandom};
      end
      DATA_IN_VECTOR_ENABLE = 4'($urandom);
      DATA_IN_SCALAR_ENABLE = 4'($urandom);
      ENGINE_DATA_OUT = {$urandom, $urandom};
      ENGINE_DATA_OUT_VECTOR_ENABLE = 1'($urandom);
      ENGINE_DATA_OUT_SCALAR_ENABLE = 1'($urandom);
      ENGINE_READY = ($urandom_range(2) == 0);
      if (c % 997 == 500) begin
        #1 RST = 1'b1;
        #1 RST = 1'b0;
      end
      tick();
    end

    REQ_IN = 4'b0000;
    ENGINE_READY = 1'b1;
    repeat (6) tick();
    chk("final_idle", DW'(GNT_OUT), '0);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/model_trainer_arbiter.md
Name: model_trainer_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one model_vector_summation engine among the four gradient accumulations of the FNN trainer: dW (req 0), dK (req 1), dU (req 2) and db (req 3).
- Grants the engine to one requester at a time and issues the engine START pulse.
- Muxes the granted requester's size, length, data and enables onto the engine, and routes the engine's output enables back to that requester.
- Waits for the engine READY, latches the final result, pulses a per-requester DONE, then rotates priority.

Parameters:
- DATA_SIZE, 64, width of every data, size and length word.
- CONTROL_SIZE, 4, passed through to the engine; no local use.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset: asynchronous, active-high.
- REQ_IN  in  4  per-requester request, held until its DONE_OUT.
- GNT_OUT  out  4  one-hot grant, registered.
- DONE_OUT  out  4  one-cycle completion pulse for the granted requester.
- SIZE_IN  in  4*DATA_SIZE  per-requester SIZE; requester n uses bits [n*DATA_SIZE +: DATA_SIZE]. The same packing applies to LENGTH_IN and DATA_IN.
- LENGTH_IN  in  4*DATA_SIZE  per-requester LENGTH.
- DATA_IN  in  4*DATA_SIZE  per-requester data word.
- DATA_IN_VECTOR_ENABLE  in  4  per-requester input vector enable.
- DATA_IN_SCALAR_ENABLE  in  4  per-requester input scalar enable.
- DATA_OUT  out  DATA_SIZE  engine data, forwarded combinationally.
- DATA_OUT_VECTOR_ENABLE  out  4  engine output vector enable, routed to the granted requester.
- DATA_OUT_SCALAR_ENABLE  out  4  engine output scalar enable, routed to the granted requester.
- RESULT_OUT  out  DATA_SIZE  engine DATA_OUT latched at READY.
- ENGINE_START  out  1  engine START.
- ENGINE_READY  in  1  engine READY.
- ENGINE_SIZE_IN  out  DATA_SIZE  muxed SIZE.
- ENGINE_LENGTH_IN  out  DATA_SIZE  muxed LENGTH.
- ENGINE_DATA_IN  out  DATA_SIZE  muxed data.
- ENGINE_DATA_IN_VECTOR_ENABLE  out  1  muxed enable.
- ENGINE_DATA_IN_SCALAR_ENABLE  out  1  muxed enable.
- ENGINE_DATA_OUT  in  DATA_SIZE  engine data.
- ENGINE_DATA_OUT_VECTOR_ENABLE  in  1  engine output vector enable.
- ENGINE_DATA_OUT_SCALAR_ENABLE  in  1  engine output scalar enable.

Behaviour:
- Reset (RST=1, asynchronous): the following are cleared to 0:
  - GNT_OUT, DONE_OUT, RESULT_OUT, ENGINE_START;
  - FSM state to IDLE;
  - round-robin pointer LAST to 3, so requester 0 has first priority.
- Reset mid-operation aborts the transaction with no DONE. The engine shares RST and resets with the arbiter.
- FSM states: IDLE, START, BUSY, RELEASE (2-bit encoding).
- IDLE:
  - REQ_IN is sampled only in this state.
  - If REQ_IN != 0, select the first set bit scanning LAST+1, LAST+2, ... modulo 4.
  - Next edge: GNT_OUT = one-hot of the winner, ENGINE_START = 1, state = START.
- START:
  - ENGINE_START is high for exactly this one cycle.
  - ENGINE_READY is ignored in this state.
  - Next state is BUSY; ENGINE_START returns to 0.
- BUSY:
  - Hold GNT_OUT.
  - On the first edge with ENGINE_READY=1: RESULT_OUT <= ENGINE_DATA_OUT, DONE_OUT <= GNT_OUT, LAST <= granted index, state = RELEASE.
- RELEASE:
  - DONE_OUT is high for this one cycle only.
  - Next edge: GNT_OUT = 0, DONE_OUT = 0, state = IDLE.
- Latency:
  - REQ at edge N gives GNT_OUT and ENGINE_START visible after N+1.
  - READY sampled at edge M gives DONE_OUT visible after M+1.
  - At least one IDLE cycle separates consecutive grants.
- Muxing (combinational on registered GNT_OUT):
  - The ENGINE_* inputs carry the granted requester's slices.
  - With no grant, all ENGINE_* data and enable outputs are 0.
  - DATA_OUT = ENGINE_DATA_OUT at all times.
  - DATA_OUT_*_ENABLE[n] = engine enable AND GNT_OUT[n]; the other bits are 0.
- Request deasserted while granted: the operation completes and DONE still pulses. There is no abort path.
- Simultaneous requests: round-robin only, so no requester waits more than 3 grants.
- Invariants:
  - GNT_OUT is always one-hot or zero.
  - DONE_OUT is always a subset of GNT_OUT.
- Arithmetic: none locally. The pointer increments modulo 4 (3 wraps to 0).

Test Plan:
- Single request: after reset, REQ_IN=0001 with SIZE slice 0 = 4 and LENGTH slice 0 = 3 -> GNT_OUT=0001 and ENGINE_START high for 1 cycle, ENGINE_SIZE_IN=4, ENGINE_LENGTH_IN=3. Then ENGINE_READY=1 with ENGINE_DATA_OUT=0x2A -> next cycle DONE_OUT=0001 and RESULT_OUT=0x2A; GNT_OUT=0 one cycle later.
- Round-robin: REQ_IN=1111 held, engine returns READY 5 cycles after START each time -> grant order 0,1,2,3,0. DONE_OUT bits match that order, with exactly one START per grant.
- Wrap-around: complete a grant to requester 3, then REQ_IN=1001 -> requester 0 granted before 3.
- Routing: while GNT_OUT=0100, drive ENGINE_DATA_OUT_VECTOR_ENABLE=1 -> DATA_OUT_VECTOR_ENABLE=0100. Requester 1 input enables toggling -> no effect on ENGINE_DATA_IN_VECTOR_ENABLE.
- Drop and READY in START: REQ_IN 0010 dropped in BUSY -> DONE_OUT=0010 still pulses. ENGINE_READY=1 during the START cycle -> ignored; FSM stays in BUSY until READY is seen in BUSY.
- Reset mid-operation: assert RST during BUSY, asynchronous between edges -> GNT_OUT, ENGINE_START, DONE_OUT and RESULT_OUT are 0 immediately, and no DONE pulse occurs. After release, REQ_IN=1000 with LAST=3 -> requester 3 is granted.
